// File: rtl/fp16_norm_round.sv
// ---------------------------------------------------------------------------
// fp16_norm_round
// Two-stage normalise / round-to-nearest-even / pack unit for FP16 results.
//   Stage 1: leading-one detect on the raw mantissa, normalising shift
//            (right by one on carry, left clamped so the exponent stays >= 1),
//            exponent adjust and subnormal detection.
//   Stage 2: round-to-nearest-even, overflow to infinity, pack.
// Both stages use valid/ready flow control; a stage loads whenever it is
// empty or its content moves on in the same cycle.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset, empties both stages
//   in_valid_i   operand valid           in_ready_o   operand accepted
//   sign_i       result sign
//   exp_i[5:0]   biased exponent 1..62 (subnormal operands arrive as 1)
//   mant_i[12:0] {carry, hidden, frac[9:0], guard}, unnormalised
//   sticky_i     OR of all bits below guard
//   out_valid_o  result valid           out_ready_i  result accepted
//   result_o     packed FP16 {sign, exp[4:0], frac[9:0]}
//   flags_o      {overflow, underflow, inexact}
//
// Build option
//   FP16_NORM_FLAGS_EN  defined: flags computed and pipelined with the result.
//                       undefined: flag logic removed, flags_o = 3'b000.
// ---------------------------------------------------------------------------
module fp16_norm_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        sign_i,
    input  logic [5:0]  exp_i,
    input  logic [12:0] mant_i,
    input  logic        sticky_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] result_o,
    output logic [2:0]  flags_o
);

    // Leading zeros of a 12-bit vector counted from bit 11; 12 when all zero.
    function automatic logic [3:0] lzc12(input logic [11:0] v);
        logic [3:0] n;
        n = 4'd12;
        // Scanning upwards lets the highest set bit win.
        for (int i = 0; i < 12; i++) begin
            if (v[i]) begin
                n = 4'(11 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic        s1_valid_r;
    logic        s1_sign_r;
    logic [6:0]  s1_exp_r;      // encoded exponent, 0 = subnormal
    logic [11:0] s1_sig_r;      // {hidden, frac[9:0], guard}
    logic        s1_sticky_r;
    logic        s2_valid_r;
    logic [15:0] s2_result_r;

    logic        s2_adv_s;
    logic        s1_adv_s;

    logic [6:0]  exp_ext_s;
    logic [6:0]  exp_m1_s;
    logic [6:0]  lz_s;
    logic [6:0]  sh_s;
    logic [6:0]  exp_adj_s;
    logic [11:0] sig_s;
    logic        sticky_s;
    logic [6:0]  exp_enc_s;

    logic        round_up_s;
    logic [16:0] sum_s;         // {exp[6:0], frac[9:0]} after rounding
    logic        ovf_s;
    logic [15:0] result_s;

    assign s2_adv_s    = !s2_valid_r || out_ready_i;
    assign s1_adv_s    = !s1_valid_r || s2_adv_s;
    assign in_ready_o  = s1_adv_s;
    assign out_valid_o = s2_valid_r;
    assign result_o    = s2_result_r;

    // Stage 1 datapath: normalising shift and exponent adjust.
    always_comb begin
        exp_ext_s = {1'b0, exp_i};
        exp_m1_s  = exp_ext_s - 7'd1;
        lz_s      = {3'b000, lzc12(mant_i[11:0])};
        sh_s      = 7'd0;
        sig_s     = mant_i[11:0];
        sticky_s  = sticky_i;
        exp_adj_s = exp_ext_s;
        if (mant_i[12]) begin
            // Carry: the old guard drops into sticky, old bit 1 becomes guard.
            sig_s     = mant_i[12:1];
            sticky_s  = sticky_i | mant_i[0];
            exp_adj_s = exp_ext_s + 7'd1;
        end else begin
            // Left shift never takes the exponent below 1; what is left
            // unnormalised is a subnormal.
            sh_s      = (lz_s < exp_m1_s) ? lz_s : exp_m1_s;
            sig_s     = mant_i[11:0] << sh_s;
            sticky_s  = sticky_i;
            exp_adj_s = exp_ext_s - sh_s;
        end
        exp_enc_s = sig_s[11] ? exp_adj_s : 7'd0;
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_exp_r    <= 7'd0;
            s1_sig_r    <= 12'd0;
            s1_sticky_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid_i;
            if (in_valid_i) begin
                s1_sign_r   <= sign_i;
                s1_exp_r    <= exp_enc_s;
                s1_sig_r    <= sig_s;
                s1_sticky_r <= sticky_s;
            end
        end
    end

    // Stage 2 datapath: RNE rounding; the increment ripples from the fraction
    // into the exponent, which also turns a rounded-up subnormal into exp 1.
    always_comb begin
        round_up_s = s1_sig_r[0] & (s1_sticky_r | s1_sig_r[1]);
        sum_s      = {s1_exp_r, s1_sig_r[10:1]} + {16'd0, round_up_s};
        ovf_s      = (sum_s[16:10] >= 7'd31);
        if (ovf_s) begin
            result_s = {s1_sign_r, 5'h1F, 10'h000};
        end else begin
            result_s = {s1_sign_r, sum_s[14:0]};
        end
    end

    // Stage 2 register; result only reloads when new data arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= 16'd0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_result_r <= result_s;
            end
        end
    end

`ifdef FP16_NORM_FLAGS_EN
    logic       inexact_s;
    logic       underflow_s;
    logic [2:0] s2_flags_r;

    // Flag derivation; overflow is always reported as inexact too.
    always_comb begin
        inexact_s   = s1_sig_r[0] | s1_sticky_r | ovf_s;
        underflow_s = (sum_s[16:10] == 7'd0) & inexact_s;
    end

    // Flag register travelling alongside the stage 2 result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_flags_r <= 3'b000;
        end else if (s2_adv_s && s1_valid_r) begin
            s2_flags_r <= {ovf_s, underflow_s, inexact_s};
        end
    end

    assign flags_o = s2_flags_r;
`else
    assign flags_o = 3'b000;
`endif

endmodule

// File: tb/tb_fp16_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fp16_norm_round
// Self-checking bench: directed corner operands, a stall scenario, a reset
// with operands in flight, then randomised traffic with random back-pressure.
// Expected results come from a value-level model: the operand is treated as
// the integer mant * 2^(exp-26), rescaled to the output quantum and rounded.
// ---------------------------------------------------------------------------
module tb_fp16_norm_round;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        sign_i;
    logic [5:0]  exp_i;
    logic [12:0] mant_i;
    logic        sticky_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] result_o;
    logic [2:0]  flags_o;

    fp16_norm_round dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sign_i      (sign_i),
        .exp_i       (exp_i),
        .mant_i      (mant_i),
        .sticky_i    (sticky_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .flags_o     (flags_o)
    );

`ifdef FP16_NORM_FLAGS_EN
    localparam logic FL_EN = 1'b1;
`else
    localparam logic FL_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] res;
        logic [2:0]  fl;
        int          t;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, expv);
        end
    endtask

    // Value-level reference: find the output binade, scale to the 10-bit
    // fraction quantum, round half to even with sticky as an infinitesimal.
    function automatic void ref_model(input logic s, input int e, input int m, input logic st,
                                      output logic [15:0] res, output logic [2:0] fl);
        int     p;
        int     eff;
        int     sh;
        int     sig;
        int     fexp;
        longint full;
        longint q;
        longint rem;
        longint half;
        logic   ru;
        logic   inex;
        logic   ovf;
        p = -1;
        for (int i = 0; i < 13; i++) begin
            if (((m >> i) & 1) != 0) p = i;
        end
        eff = (p < 0) ? 1 : (e + p - 11);
        if (eff < 1) eff = 1;
        sh   = 20 + e - eff - 1;
        full = longint'(m) << sh;
        q    = full >> 20;
        rem  = full - (q << 20);
        half = 64'd524288;
        ru   = (rem > half) || ((rem == half) && (st || (q % 2 == 1)));
        inex = (rem != 0) || st;
        sig  = int'(q) + int'(ru);
        if (sig >= 2048) begin
            sig = sig / 2;
            eff = eff + 1;
        end
        fexp = (sig >= 1024) ? eff : 0;
        ovf  = 1'b0;
        if (fexp >= 31) begin
            res  = {s, 5'h1F, 10'h000};
            ovf  = 1'b1;
            inex = 1'b1;
        end else begin
            res = {s, 5'(fexp), 10'(sig % 1024)};
        end
        fl = FL_EN ? {ovf, (fexp == 0) && inex, inex} : 3'b000;
    endfunction

    // One clock cycle: drive at the falling edge, then check the settled
    // outputs and account for the handshakes the next rising edge performs.
    task automatic step(input logic v, input logic s, input logic [5:0] e, input logic [12:0] m,
                        input logic st, input logic ordy, input logic lit_en,
                        input logic [15:0] lit_res, input logic [2:0] lit_fl, output logic acc);
        exp_t        it;
        logic        want_ov;
        logic [15:0] r;
        logic [2:0]  f;
        @(negedge clk);
        in_valid_i  = v;
        sign_i      = s;
        exp_i       = e;
        mant_i      = m;
        sticky_i    = st;
        out_ready_i = ordy;
        #1;
        cyc++;
        check("in_ready", 32'(in_ready_o), 32'(!((exp_q.size() == 2) && !ordy)));
        want_ov = (exp_q.size() > 0) && ((cyc - exp_q[0].t) >= 2);
        check("out_valid", 32'(out_valid_o), 32'(want_ov));
        if (want_ov) begin
            check("result", 32'(result_o), 32'(exp_q[0].res));
            check("flags", 32'(flags_o), 32'(exp_q[0].fl));
            if (ordy) void'(exp_q.pop_front());
        end
        acc = v && in_ready_o;
        if (acc) begin
            ref_model(s, int'(e), int'(m), st, r, f);
            it.res = lit_en ? lit_res : r;
            it.fl  = lit_en ? lit_fl : f;
            it.t   = cyc;
            exp_q.push_back(it);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        cyc++;
        exp_q.delete();
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_flags", 32'(flags_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 6'd1, 13'd0, 1'b0, 1'b1, 1'b0, 16'd0, 3'd0, a);
        end
    endtask

    initial begin
        logic        a;
        logic [12:0] ops [4];
        int          idx;
        total       = 0;
        bad         = 0;
        cyc         = 0;
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        sign_i      = 1'b0;
        exp_i       = 6'd1;
        mant_i      = 13'd0;
        sticky_i    = 1'b0;
        out_ready_i = 1'b1;
        do_reset();

        // Directed corners, with expectations written out by hand.
        step(1'b1, 1'b0, 6'd15, 13'h1000, 1'b0, 1'b1, 1'b1, 16'h4000, 3'b000, a);
        step(1'b1, 1'b0, 6'd15, 13'h0002, 1'b0, 1'b1, 1'b1, 16'h1400, 3'b000, a);
        step(1'b1, 1'b0, 6'd3,  13'h0010, 1'b0, 1'b1, 1'b1, 16'h0020, 3'b000, a);
        step(1'b1, 1'b0, 6'd15, 13'h0803, 1'b0, 1'b1, 1'b1, 16'h3C02, FL_EN ? 3'b001 : 3'b000, a);
        step(1'b1, 1'b0, 6'd15, 13'h0801, 1'b0, 1'b1, 1'b1, 16'h3C00, FL_EN ? 3'b001 : 3'b000, a);
        step(1'b1, 1'b1, 6'd30, 13'h1FFF, 1'b0, 1'b1, 1'b1, 16'hFC00, FL_EN ? 3'b101 : 3'b000, a);
        step(1'b1, 1'b1, 6'd20, 13'h0000, 1'b0, 1'b1, 1'b1, 16'h8000, 3'b000, a);
        step(1'b1, 1'b0, 6'd1,  13'h07FF, 1'b1, 1'b1, 1'b1, 16'h0400, FL_EN ? 3'b001 : 3'b000, a);
        idle(4);

        // Four operands against a stalled output for the first three cycles.
        ops[0] = 13'h0A55;
        ops[1] = 13'h1234;
        ops[2] = 13'h0123;
        ops[3] = 13'h0FFF;
        idx = 0;
        for (int k = 0; k < 12 && idx < 4; k++) begin
            step(1'b1, 1'b0, 6'd17, ops[idx], 1'b0, (k >= 3), 1'b0, 16'd0, 3'd0, a);
            if (k == 2) check("stall_in_ready", 32'(in_ready_o), 32'd0);
            if (a) idx++;
        end
        check("stall_all_sent", 32'(idx), 32'd4);
        idle(4);
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two operands in flight; nothing stale may appear after.
        step(1'b1, 1'b0, 6'd10, 13'h0C00, 1'b0, 1'b1, 1'b0, 16'd0, 3'd0, a);
        step(1'b1, 1'b1, 6'd12, 13'h0456, 1'b1, 1'b1, 1'b0, 16'd0, 3'd0, a);
        do_reset();
        idle(4);

        // Randomised traffic with random back-pressure.
        for (int k = 0; k < 3000; k++) begin
            logic [5:0]  re;
            logic [12:0] rm;
            re = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 12)) : 6'($urandom_range(1, 62));
            rm = 13'($urandom_range(0, 8191) >> $urandom_range(0, 13));
            step(($urandom_range(0, 3) != 0), 1'($urandom), re, rm, 1'($urandom),
                 ($urandom_range(0, 9) < 7), 1'b0, 16'd0, 3'd0, a);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) idle(1);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
